selevy_mem_arb: RTL and testbench

Arbiter that shares the single pipelined memory port of the selevy core between instruction fetch (IF) and load/store (D).
- Issues at most one access per cycle to memory.
- Tags each in-flight access and routes read data back to the requester that issued it.
- Bounds fetch starvation with a data-streak limit.
- Sits between the core's fetch/LSU stages and the unified memory.

---
 rtl/selevy_mem_arb.sv | 114 +++++++++++
 tb/tb_selevy_mem_arb.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/selevy_mem_arb.sv
// Shares the single pipelined memory port between instruction fetch and load/store.
// Grants are same-cycle; a tag pipe routes read data back to the issuing requester.
module selevy_mem_arb #(
  parameter int unsigned ADDR_W      = 32,
  parameter int unsigned DATA_W      = 32,
  parameter int unsigned MEM_LAT     = 1,
  parameter int unsigned MAX_DSTREAK = 4
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_gnt,
  output logic                if_rvalid,
  output logic [DATA_W-1:0]   if_rdata,
  input  logic                d_req,
  input  logic                d_we,
  input  logic [DATA_W/8-1:0] d_be,
  input  logic [ADDR_W-1:0]   d_addr,
  input  logic [DATA_W-1:0]   d_wdata,
  output logic                d_gnt,
  output logic                d_rvalid,
  output logic [DATA_W-1:0]   d_rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [DATA_W/8-1:0] mem_be,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                busy
);

  localparam int unsigned BE_W = DATA_W / 8;
  localparam int unsigned SK_W = $clog2(MAX_DSTREAK) + 1;
  localparam logic [SK_W-1:0] SK_MAX = SK_W'(MAX_DSTREAK);

  logic [SK_W-1:0]    streak;
  logic [MEM_LAT-1:0] tag_v;
  logic [MEM_LAT-1:0] tag_d;
  logic               if_win;
  logic               d_win;
  logic               rd_issue;
  logic               top_v;
  logic               top_d;

  // Winner selection: D by default, IF once the D streak has hit its limit.
  always_comb begin
    if_win = 1'b0;
    d_win  = 1'b0;
    if (!reset) begin
      if (if_req && (!d_req || streak == SK_MAX)) begin
        if_win = 1'b1;
      end else if (d_req) begin
        d_win = 1'b1;
      end
    end
  end

  assign if_gnt   = if_win;
  assign d_gnt    = d_win;
  assign rd_issue = if_win | (d_win & ~d_we);

  // Memory port mux driven straight from the winner; idle port is all zeros.
  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_be    = '0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (if_win) begin
      mem_en   = 1'b1;
      mem_be   = {BE_W{1'b1}};
      mem_addr = if_addr;
    end else if (d_win) begin
      mem_en    = 1'b1;
      mem_we    = d_we;
      mem_be    = d_be;
      mem_addr  = d_addr;
      mem_wdata = d_wdata;
    end
  end

  // D streak: counts D wins that made a waiting fetch wait; cleared when fetch wins or idles.
  always_ff @(posedge CLK) begin
    if (reset || !if_req || if_win) begin
      streak <= '0;
    end else if (d_win && streak != SK_MAX) begin
      streak <= streak + SK_W'(1);
    end
  end

  // Tag pipe: one stage per cycle of memory latency; only reads carry a valid tag.
  always_ff @(posedge CLK) begin
    if (reset) begin
      tag_v <= '0;
      tag_d <= '0;
    end else begin
      tag_v <= MEM_LAT'({tag_v, rd_issue});
      tag_d <= MEM_LAT'({tag_d, d_win});
    end
  end

  assign top_v = tag_v[MEM_LAT-1];
  assign top_d = tag_d[MEM_LAT-1];

  // Response routing; a reset cycle suppresses any response still draining out.
  assign if_rvalid = ~reset & top_v & ~top_d;
  assign d_rvalid  = ~reset & top_v & top_d;
  assign if_rdata  = if_rvalid ? mem_rdata : '0;
  assign d_rdata   = d_rvalid  ? mem_rdata : '0;

  assign busy = mem_en | (|tag_v);

endmodule

// File: tb/tb_selevy_mem_arb.sv
// Bench for selevy_mem_arb: directed scenarios followed by randomized traffic,
// checked every cycle against a transaction-level model of the arbiter and memory.
module tb_selevy_mem_arb;

  localparam int unsigned AW   = 32;
  localparam int unsigned DW   = 32;
  localparam int unsigned LAT  = 3;
  localparam int unsigned MAXD = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req;
  logic [AW-1:0] if_addr;
  logic          if_gnt, if_rvalid;
  logic [DW-1:0] if_rdata;
  logic          d_req, d_we;
  logic [3:0]    d_be;
  logic [AW-1:0] d_addr;
  logic [DW-1:0] d_wdata;
  logic          d_gnt, d_rvalid;
  logic [DW-1:0] d_rdata;
  logic          mem_en, mem_we;
  logic [3:0]    mem_be;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata;
  logic          busy;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  selevy_mem_arb #(
    .ADDR_W(AW), .DATA_W(DW), .MEM_LAT(LAT), .MAX_DSTREAK(MAXD)
  ) u_dut (
    .CLK(clk), .reset(rst),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_be(d_be), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_be(mem_be), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
  );

  function automatic logic [31:0] hashf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                        input logic [3:0] be);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = wd[8*i +: 8];
    return r;
  endfunction

  // Memory environment: answers the DUT's port with fixed latency, applies writes.
  logic [31:0] emem [logic [31:0]];
  logic [31:0] rpipe [LAT] = '{default: 32'h0};
  assign mem_rdata = rpipe[LAT-1];

  always @(posedge clk) begin
    logic [31:0] rd;
    rd = 32'h0;
    if (mem_en && !mem_we) rd = emem.exists(mem_addr) ? emem[mem_addr] : hashf(mem_addr);
    for (int i = LAT - 1; i > 0; i--) rpipe[i] <= rpipe[i-1];
    rpipe[0] <= rd;
    if (mem_en && mem_we)
      emem[mem_addr] = merge(emem.exists(mem_addr) ? emem[mem_addr] : hashf(mem_addr),
                             mem_wdata, mem_be);
  end

  // Reference model state: expected memory image, streak, outstanding reads.
  typedef struct {
    int          due;
    bit          own_d;
    logic [31:0] data;
  } rsp_t;

  logic [31:0] rmem [logic [31:0]];
  rsp_t        rspq [$];
  int          streak = 0;
  int          cyc    = 0;
  bit          g_if   = 0;
  bit          g_d    = 0;
  logic        obs_if = 1'b0;

  function automatic logic [31:0] mread(input logic [31:0] a);
    return rmem.exists(a) ? rmem[a] : hashf(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
    end
  endtask

  // One clock cycle: check all outputs mid-cycle, then advance the model across the edge.
  task automatic tick();
    bit e_if, e_d, e_en, e_we, e_ifv, e_dv, e_busy;
    logic [3:0]  e_be;
    logic [31:0] e_addr, e_wd, e_ifd, e_dd;
    rsp_t r;
    @(negedge clk);
    e_if = !rst && if_req && (!d_req || streak == MAXD);
    e_d  = !rst && d_req && !e_if;
    e_en = e_if || e_d;
    e_we = 0; e_be = 4'h0; e_addr = 32'h0; e_wd = 32'h0;
    if (e_if) begin
      e_be = 4'hF; e_addr = if_addr;
    end else if (e_d) begin
      e_we = d_we; e_be = d_be; e_addr = d_addr; e_wd = d_wdata;
    end
    e_ifv = 0; e_dv = 0; e_ifd = 32'h0; e_dd = 32'h0;
    if (rspq.size() > 0 && rspq[0].due == cyc && !rst) begin
      if (rspq[0].own_d) begin e_dv = 1; e_dd = rspq[0].data; end
      else begin e_ifv = 1; e_ifd = rspq[0].data; end
    end
    e_busy = e_en || (rspq.size() > 0);

    chk("if_gnt",    64'(if_gnt),    64'(e_if));
    chk("d_gnt",     64'(d_gnt),     64'(e_d));
    chk("mem_en",    64'(mem_en),    64'(e_en));
    chk("mem_we",    64'(mem_we),    64'(e_we));
    chk("mem_be",    64'(mem_be),    64'(e_be));
    chk("mem_addr",  64'(mem_addr),  64'(e_addr));
    chk("mem_wdata", 64'(mem_wdata), 64'(e_wd));
    chk("if_rvalid", 64'(if_rvalid), 64'(e_ifv));
    chk("if_rdata",  64'(if_rdata),  64'(e_ifd));
    chk("d_rvalid",  64'(d_rvalid),  64'(e_dv));
    chk("d_rdata",   64'(d_rdata),   64'(e_dd));
    chk("busy",      64'(busy),      64'(e_busy));
    obs_if = if_gnt;
    g_if = e_if;
    g_d  = e_d;

    if (rspq.size() > 0 && rspq[0].due == cyc) void'(rspq.pop_front());
    if (rst) begin
      streak = 0;
      rspq.delete();
    end else begin
      if (!if_req || e_if) streak = 0;
      else if (e_d) streak++;
      if (e_if) begin
        r.due = cyc + LAT; r.own_d = 0; r.data = mread(if_addr); rspq.push_back(r);
      end else if (e_d && !d_we) begin
        r.due = cyc + LAT; r.own_d = 1; r.data = mread(d_addr); rspq.push_back(r);
      end else if (e_d && d_we) begin
        rmem[d_addr] = merge(mread(d_addr), d_wdata, d_be);
      end
    end
    cyc++;
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    if_req = 0; d_req = 0;
  endtask

  initial begin
    logic [9:0] gseq;
    logic [9:0] gexp;
    rmem[32'h100] = 32'hDEAD_BEEF; emem[32'h100] = 32'hDEAD_BEEF;
    rmem[32'h0]   = 32'hA;         emem[32'h0]   = 32'hA;
    rmem[32'h10]  = 32'hB;         emem[32'h10]  = 32'hB;
    rmem[32'h4]   = 32'hC;         emem[32'h4]   = 32'hC;

    rst = 1; if_req = 1; if_addr = 32'h200; d_req = 1; d_we = 0; d_be = 4'hF;
    d_addr = 32'h300; d_wdata = 32'h0;
    @(posedge clk); #1;

    // Reset held with both requesting: no grants; first free cycle grants D.
    tick(); tick();
    rst = 0;
    tick();
    idle();
    for (int i = 0; i < 5; i++) tick();

    // Lone fetch read returns after the memory latency.
    if_req = 1; if_addr = 32'h100;
    tick();
    idle();
    for (int i = 0; i < LAT + 1; i++) tick();

    // Both requesting continuously: fetch wins every fifth cycle.
    if_req = 1; if_addr = 32'h8; d_req = 1; d_we = 0; d_addr = 32'h20;
    gseq = '0;
    for (int i = 0; i < 10; i++) begin
      tick();
      gseq[9-i] = obs_if;
    end
    gexp = 10'b0000100001;
    chk("grant_pattern", 64'(gseq), 64'(gexp));
    idle();
    for (int i = 0; i < LAT + 1; i++) tick();

    // Partial-byte write goes straight through and never responds.
    d_req = 1; d_we = 1; d_be = 4'b0011; d_addr = 32'h40; d_wdata = 32'h1234_5678;
    tick();
    idle();
    for (int i = 0; i < 8; i++) tick();

    // Interleaved reads return in issue order to the right owner.
    if_req = 1; if_addr = 32'h0; tick();
    if_req = 0; d_req = 1; d_we = 0; d_addr = 32'h10; tick();
    d_req = 0; if_req = 1; if_addr = 32'h4; tick();
    idle();
    for (int i = 0; i < 5; i++) tick();

    // Reset while a read is in flight kills its response.
    if_req = 1; if_addr = 32'h100; tick();
    idle(); rst = 1; tick();
    rst = 0;
    for (int i = 0; i < 6; i++) tick();

    // Randomized traffic, honouring the hold-until-granted rule.
    for (int n = 0; n < 400; n++) begin
      rst = ($urandom_range(0, 63) == 0);
      if (!(if_req && !g_if)) begin
        if_req  = 1'($urandom_range(0, 1));
        if_addr = 32'($urandom_range(0, 15)) << 2;
      end
      if (!(d_req && !g_d)) begin
        d_req   = 1'($urandom_range(0, 1));
        d_we    = ($urandom_range(0, 2) == 0);
        d_be    = 4'($urandom);
        d_addr  = 32'($urandom_range(0, 15)) << 2;
        d_wdata = $urandom;
      end
      tick();
    end
    rst = 0; idle();
    for (int i = 0; i < LAT + 2; i++) tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
